ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  AW  4  RAM address width (16 words)
  DW  8  RAM data width
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk      input   1   single clock; all state updates on rising edge
  rst_n    input   1   asynchronous, active-low reset
  req0     input   1   requester 0 access request; held until gnt0
  we0      input   1   requester 0 command: 1 = write, 0 = read
  addr0    input   AW  requester 0 address
  wdata0   input   DW  requester 0 write data
  gnt0     output  1   one-cycle pulse: requester 0 command accepted
  rvalid0  output  1   one-cycle pulse: rdata holds requester 0 read result
  req1, we1, addr1, wdata1, gnt1, rvalid1  same widths and meanings for requester 1
  rdata    output  DW  registered read data, shared by both requesters
  ram_we   output  1   RAM write enable
  ram_re   output  1   RAM read enable
  ram_addr output  AW  RAM address
  ram_din  output  DW  RAM write data
  ram_dout input   DW  RAM read data, valid one cycle after ram_re sampled

Function
REQ-003 The FSM SHALL have states IDLE, WR, RD and RDATA; at most one RAM access SHALL be in flight.
REQ-004 In IDLE, if any req is high at a clock edge, the arbiter SHALL pick a winner, latch its we/addr/wdata, and go to WR (we=1) or RD (we=0); otherwise it SHALL stay in IDLE.
REQ-005 In WR, ram_we=1, ram_addr/ram_din SHALL equal the latched values, the winner's gnt SHALL be high, and the next state SHALL be IDLE (2 cycles per write).
REQ-006 In RD, ram_re=1, ram_addr SHALL equal the latched address, the winner's gnt SHALL be high, and the next state SHALL be RDATA.
REQ-007 In RDATA, ram_dout SHALL be captured into rdata at the closing edge, the winner's rvalid SHALL pulse high the following cycle (in IDLE), and the next state SHALL be IDLE (3 cycles from IDLE to rvalid).
REQ-008 The RAM outputs SHALL be driven from registered state only.
REQ-009 ram_we, ram_re and all gnt/rvalid outputs SHALL be 0 outside the states named above.
REQ-010 gnt0 and gnt1 SHALL never both be high; rvalid0 and rvalid1 SHALL never both be high.
REQ-011 Requesters SHALL drop req in the cycle after gnt; req asserted during a non-IDLE state SHALL wait, with no loss and no duplicate service.
REQ-012 Simultaneous req0 and req1 in IDLE SHALL be resolved per REQ-016; a lone requester SHALL always win.
REQ-013 rdata SHALL hold its last value until the next RDATA capture.

Reset
REQ-014 rst_n low SHALL immediately force state IDLE, the last-served pointer to 1, rdata=0, and all gnt, rvalid, ram_we, ram_re, ram_addr and ram_din outputs to 0.
REQ-015 Reset mid-access SHALL abort the access with no further gnt or rvalid for it; operation SHALL resume from IDLE on the first edge after rst_n rises.

Configuration
REQ-016 Macro RAM_ARB_RR_EN:
  - Defined: round-robin; on contention the requester not last served SHALL win; the pointer SHALL update on each grant.
  - Undefined: fixed priority; req0 SHALL always win contention and the pointer logic SHALL be absent.

Verification
REQ-017 The bench SHALL cover at least these directed scenarios:
  - Write then read: req0 write addr 2 = 0xAA, then req0 read addr 2 -> gnt0 in WR, then rvalid0 with rdata=0xAA exactly 3 cycles after the read is seen in IDLE.
  - Contention, RR_EN defined: req0 and req1 both write (addr 4 = 0x55, addr 5 = 0x66) from reset -> requester 0 granted first, then requester 1; RAM holds both values.
  - Contention, RR_EN undefined: req0 and req1 held continuously -> gnt0 every access and gnt1 never until req0 drops.
  - Back-to-back traffic: req1 read addr 4 while req0 issues a write -> no overlapping ram_we/ram_re; rvalid1 with rdata=0x55.
  - Reset during RD: rst_n low during RD -> outputs zero at once; no rvalid; rdata=0.
  - Address wrap: write addr 15 = 0xF0, read addr 15 and addr 0 -> 0xF0 and prior addr-0 data, with no aliasing.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port RAM, one access in flight at a time.
// Define RAM_ARB_RR_EN for round-robin contention; default build is fixed priority (req0 wins).
module ram_arbiter #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          ram_we,
  output logic          ram_re,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  // state | meaning
  // IDLE  | waiting for a request; arbitrate and latch the winner's command
  // WR    | RAM write issued, winner granted
  // RD    | RAM read issued, winner granted
  // RDATA | RAM output valid; captured into rdata at the closing edge
  typedef enum logic [1:0] {IDLE, WR, RD, RDATA} state_t;

  state_t        state, state_nxt;
  logic          sel, sel_nxt;
  logic          pick;
  logic [AW-1:0] addr_q, addr_nxt;
  logic [DW-1:0] din_q, din_nxt;
  logic [DW-1:0] rdata_q;
  logic          rvalid0_q, rvalid1_q;

`ifdef RAM_ARB_RR_EN
  logic last_q;

  // On contention the requester not served last wins.
  always_comb begin
    if (req0 && req1) pick = ~last_q;
    else              pick = req1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           last_q <= 1'b1;
    else if (state == IDLE && (req0 || req1)) last_q <= pick;
  end
`else
  always_comb pick = ~req0;
`endif

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    addr_nxt  = addr_q;
    din_nxt   = din_q;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          sel_nxt   = pick;
          addr_nxt  = pick ? addr1 : addr0;
          din_nxt   = pick ? wdata1 : wdata0;
          state_nxt = (pick ? we1 : we0) ? WR : RD;
        end
      end
      WR:      state_nxt = IDLE;
      RD:      state_nxt = RDATA;
      RDATA:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      rdata_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      addr_q    <= addr_nxt;
      din_q     <= din_nxt;
      rvalid0_q <= (state == RDATA) && !sel;
      rvalid1_q <= (state == RDATA) && sel;
      if (state == RDATA) rdata_q <= ram_dout;
    end
  end

  // All RAM-side and handshake outputs decode straight from flops.
  assign ram_we   = (state == WR);
  assign ram_re   = (state == RD);
  assign ram_addr = addr_q;
  assign ram_din  = din_q;
  assign gnt0     = (state == WR || state == RD) && !sel;
  assign gnt1     = (state == WR || state == RD) && sel;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural 16x8 RAM behind it.
// Grant order expectations follow RAM_ARB_RR_EN when it is defined.
module tb_ram_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, ram_we, ram_re;
  logic [DW-1:0] rdata, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    if (ram_re) ram_dout <= mem[ram_addr];
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } cmd_t;

  cmd_t          cq0[$], cq1[$];
  logic [DW-1:0] rq0[$], rq1[$];
  int            gq[$];
  int            checks = 0;
  int            errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input logic we, input int addr, input int data);
    cmd_t c;
    c.we    = we;
    c.addr  = AW'(addr);
    c.wdata = we ? DW'(data) : '0;
    c.exp   = we ? '0 : DW'(data);
    return c;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    @(negedge clk) rst_n = 1'b1;
    #4;
  endtask

  // Drives both command queues as requesters and scores grants and read returns.
  task automatic run(input int budget, input bit lat_chk);
    cmd_t c0, c1;
    bit   a0 = 0, a1 = 0, done = 0;
    int   p0 = 0, p1 = 0, g0 = 0, g1 = 0, exp_id, t;
    for (int n = 0; n < budget; n++) begin
      if (!a0 && cq0.size() > 0) begin
        c0 = cq0.pop_front(); a0 = 1; p0 = n;
        req0 = 1; we0 = c0.we; addr0 = c0.addr; wdata0 = c0.wdata;
        if (!c0.we) rq0.push_back(c0.exp);
      end
      if (!a1 && cq1.size() > 0) begin
        c1 = cq1.pop_front(); a1 = 1; p1 = n;
        req1 = 1; we1 = c1.we; addr1 = c1.addr; wdata1 = c1.wdata;
        if (!c1.we) rq1.push_back(c1.exp);
      end
      if (!a0 && !a1 && cq0.size() == 0 && cq1.size() == 0 && rq0.size() == 0 && rq1.size() == 0) begin
        done = 1;
        break;
      end
      @(posedge clk); #1;
      t = n + 1;
      check_val("gnt_excl", gnt0 & gnt1, 0);
      check_val("rv_excl", rvalid0 & rvalid1, 0);
      check_val("ram_excl", ram_we & ram_re, 0);
      if (gnt0 || gnt1) begin
        exp_id = (gq.size() > 0) ? gq.pop_front() : 2;
        check_val("gnt_order", gnt1, exp_id);
      end
      if (gnt0) begin
        check_val("gnt0_active", a0, 1);
        if (a0) begin
          check_val("gnt0_cmd", {ram_we, ram_re, ram_addr}, {c0.we, ~c0.we, c0.addr});
          if (c0.we) check_val("gnt0_din", ram_din, c0.wdata);
          if (lat_chk) check_val("gnt0_lat", t - p0, 1);
          g0 = t; a0 = 0; req0 = 0;
        end
      end
      if (gnt1) begin
        check_val("gnt1_active", a1, 1);
        if (a1) begin
          check_val("gnt1_cmd", {ram_we, ram_re, ram_addr}, {c1.we, ~c1.we, c1.addr});
          if (c1.we) check_val("gnt1_din", ram_din, c1.wdata);
          if (lat_chk) check_val("gnt1_lat", t - p1, 1);
          g1 = t; a1 = 0; req1 = 0;
        end
      end
      if (rvalid0) begin
        check_val("rv0_pending", rq0.size() > 0, 1);
        if (rq0.size() > 0) check_val("rv0_data", rdata, rq0.pop_front());
        check_val("rv0_lat", t - g0, 2);
      end
      if (rvalid1) begin
        check_val("rv1_pending", rq1.size() > 0, 1);
        if (rq1.size() > 0) check_val("rv1_data", rdata, rq1.pop_front());
        check_val("rv1_lat", t - g1, 2);
      end
    end
    check_val("run_done", done, 1);
    req0 = 0; req1 = 0;
    cq0.delete(); cq1.delete(); rq0.delete(); rq1.delete(); gq.delete();
  endtask

  initial begin
    bit hit;
    #12;
    check_val("rst_outs", {gnt0, gnt1, rvalid0, rvalid1, ram_we, ram_re, ram_addr, ram_din}, 0);
    check_val("rst_rdata", rdata, 0);
    @(negedge clk) rst_n = 1'b1;
    #4;

    // lone write then read on requester 0
    cq0.push_back(mk(1, 2, 8'hAA)); gq.push_back(0);
    run(20, 1);
    idle(2);
    cq0.push_back(mk(0, 2, 8'hAA)); gq.push_back(0);
    run(20, 1);
    idle(2);

    // contention from reset; requester 0 keeps requesting back-to-back
    do_reset();
    cq0.push_back(mk(1, 4, 8'h55)); cq0.push_back(mk(1, 7, 8'h77)); cq0.push_back(mk(1, 8, 8'h88));
    cq1.push_back(mk(1, 5, 8'h66));
`ifdef RAM_ARB_RR_EN
    gq.push_back(0); gq.push_back(1); gq.push_back(0); gq.push_back(0);
`else
    gq.push_back(0); gq.push_back(0); gq.push_back(0); gq.push_back(1);
`endif
    run(40, 0);
    idle(1);
    check_val("mem4", mem[4], 8'h55);
    check_val("mem5", mem[5], 8'h66);
    check_val("mem7", mem[7], 8'h77);
    check_val("mem8", mem[8], 8'h88);

    // read on 1 racing a write on 0
    cq1.push_back(mk(0, 4, 8'h55));
    cq0.push_back(mk(1, 9, 8'h99));
`ifdef RAM_ARB_RR_EN
    gq.push_back(1); gq.push_back(0);
`else
    gq.push_back(0); gq.push_back(1);
`endif
    run(30, 0);
    cq0.push_back(mk(1, 10, 8'hA5)); gq.push_back(0);
    run(20, 0);
    idle(1);
    check_val("mem9", mem[9], 8'h99);
    check_val("rdata_hold", rdata, 8'h55);

    // address extremes
    cq0.push_back(mk(1, 0, 8'h3C)); cq0.push_back(mk(1, 15, 8'hF0));
    gq.push_back(0); gq.push_back(0);
    run(20, 0);
    cq1.push_back(mk(0, 15, 8'hF0)); cq1.push_back(mk(0, 0, 8'h3C));
    gq.push_back(1); gq.push_back(1);
    run(30, 0);

    // reset while the read is on the RAM port
    idle(2);
    req0 = 1; we0 = 0; addr0 = 4'd2;
    hit = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ram_re) begin hit = 1; break; end
    end
    check_val("rd_reached", hit, 1);
    req0 = 0;
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_mid_outs", {gnt0, gnt1, rvalid0, rvalid1, ram_we, ram_re, ram_addr, ram_din}, 0);
    check_val("rst_mid_rdata", rdata, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_val("rst_no_resp", {gnt0, gnt1, rvalid0, rvalid1}, 0);
    end

    // operation resumes after reset
    cq1.push_back(mk(0, 2, 8'hAA)); gq.push_back(1);
    run(20, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
